// File: rtl/conv_seq_ctrl.sv
// Phase sequencer between the APB register block and the convolution streaming datapath.
// Optional stall watchdog enabled by defining CONV_CTRL_TIMEOUT_EN (limit set by TIMEOUT_CYC).
module conv_seq_ctrl #(
    parameter int CNT_W = 22
`ifdef CONV_CTRL_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 4096
`endif
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       conv_start,
    input  logic [2:0] COMMAND,
    input  logic [8:0] InCh,
    input  logic [8:0] OutCh,
    input  logic [5:0] FLength,
    output logic       rx_en,
    input  logic       rx_fire,
    output logic       tx_en,
    input  logic       tx_fire,
    output logic       tx_last,
    output logic [1:0] buf_sel,
    output logic       compute_start,
    input  logic       compute_done,
    output logic       F_writedone,
    output logic       B_writedone,
    output logic       rdy_to_transmit,
    output logic       transmit_done,
    input  logic       F_writedone_respond,
    input  logic       B_writedone_respond,
    input  logic       rdy_to_transmit_respond,
    input  logic       transmit_done_respond,
    output logic       conv_done,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {IDLE, CALC, RX, COMP, TX, HS} state_t;

    state_t           state;
    logic [2:0]       cmd_q;
    logic [8:0]       inch_q;
    logic [8:0]       outch_q;
    logic [5:0]       flen_q;
    logic [CNT_W-1:0] beats;
    logic [CNT_W-1:0] count;
    logic             conv_start_d;

    logic             start_edge;
    logic             last_beat;
    logic             hs_respond;
    logic [23:0]      bytes_calc;
    logic [CNT_W-1:0] beats_calc;

    assign start_edge = conv_start & ~conv_start_d;
    assign last_beat  = (count == beats - CNT_W'(1));
    assign tx_last    = tx_en & last_beat;

    // Transfer size in bytes for the latched command, rounded up to 32-bit beats
    always_comb begin
        bytes_calc = '0;
        case (cmd_q)
            3'd1:    bytes_calc = 24'(outch_q) * 24'(inch_q) * 24'd9;
            3'd2:    bytes_calc = 24'(outch_q);
            3'd3:    bytes_calc = 24'(inch_q) * 24'(flen_q) * 24'(flen_q);
            3'd4:    bytes_calc = 24'(outch_q) * 24'(flen_q) * 24'(flen_q);
            default: bytes_calc = '0;
        endcase
        beats_calc = CNT_W'((bytes_calc + 24'd3) >> 2);
    end

    always_comb begin
        hs_respond = 1'b0;
        case (cmd_q)
            3'd1:    hs_respond = F_writedone_respond;
            3'd2:    hs_respond = B_writedone_respond;
            3'd3:    hs_respond = rdy_to_transmit_respond;
            3'd4:    hs_respond = transmit_done_respond;
            default: hs_respond = 1'b0;
        endcase
    end

`ifdef CONV_CTRL_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);

    logic [STALL_W-1:0] stall_cnt;
    logic               stall_hit;
    logic               progress;

    assign stall_hit = (stall_cnt == STALL_W'(TIMEOUT_CYC - 1));
    assign progress  = ((state == RX) & rx_fire & rx_en) | ((state == TX) & tx_fire & tx_en)
                     | ((state == COMP) & compute_done);
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state           <= IDLE;
            cmd_q           <= '0;
            inch_q          <= '0;
            outch_q         <= '0;
            flen_q          <= '0;
            beats           <= '0;
            count           <= '0;
            conv_start_d    <= 1'b0;
            rx_en           <= 1'b0;
            tx_en           <= 1'b0;
            buf_sel         <= '0;
            compute_start   <= 1'b0;
            F_writedone     <= 1'b0;
            B_writedone     <= 1'b0;
            rdy_to_transmit <= 1'b0;
            transmit_done   <= 1'b0;
            conv_done       <= 1'b0;
            busy            <= 1'b0;
            err             <= 1'b0;
`ifdef CONV_CTRL_TIMEOUT_EN
            stall_cnt       <= '0;
`endif
        end else begin
            conv_start_d  <= conv_start;
            compute_start <= 1'b0;
            conv_done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        if (COMMAND >= 3'd5) begin
                            err <= 1'b1;
                        end else if (COMMAND != 3'd0) begin
                            cmd_q   <= COMMAND;
                            inch_q  <= InCh;
                            outch_q <= OutCh;
                            flen_q  <= FLength;
                            err     <= 1'b0;
                            busy    <= 1'b1;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    beats <= beats_calc;
                    count <= '0;
                    if (beats_calc == '0) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cmd_q == 3'd4) begin
                        tx_en <= 1'b1;
                        state <= TX;
                    end else begin
                        rx_en   <= 1'b1;
                        buf_sel <= cmd_q[1:0] - 2'd1;
                        state   <= RX;
                    end
                end
                RX: begin
                    if (rx_fire && rx_en) begin
                        count <= count + CNT_W'(1);
                        if (last_beat) begin
                            rx_en <= 1'b0;
                            if (cmd_q == 3'd3) begin
                                compute_start <= 1'b1;
                                state         <= COMP;
                            end else begin
                                F_writedone <= (cmd_q == 3'd1);
                                B_writedone <= (cmd_q == 3'd2);
                                state       <= HS;
                            end
                        end
                    end
                end
                COMP: begin
                    if (compute_done) begin
                        rdy_to_transmit <= 1'b1;
                        state           <= HS;
                    end
                end
                TX: begin
                    if (tx_fire && tx_en) begin
                        count <= count + CNT_W'(1);
                        if (last_beat) begin
                            tx_en         <= 1'b0;
                            transmit_done <= 1'b1;
                            state         <= HS;
                        end
                    end
                end
                HS: begin
                    if (hs_respond) begin
                        F_writedone     <= 1'b0;
                        B_writedone     <= 1'b0;
                        rdy_to_transmit <= 1'b0;
                        transmit_done   <= 1'b0;
                        conv_done       <= 1'b1;
                        busy            <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef CONV_CTRL_TIMEOUT_EN
            // Watchdog abort overrides whatever the phase logic decided this cycle
            if (state == RX || state == TX || state == COMP) begin
                if (progress) begin
                    stall_cnt <= '0;
                end else if (stall_hit) begin
                    stall_cnt     <= '0;
                    err           <= 1'b1;
                    rx_en         <= 1'b0;
                    tx_en         <= 1'b0;
                    compute_start <= 1'b0;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end else begin
                    stall_cnt <= stall_cnt + STALL_W'(1);
                end
            end else begin
                stall_cnt <= '0;
            end
`endif
        end
    end

endmodule

// File: doc/conv_seq_ctrl.md
# conv_seq_ctrl

Phase sequencer for the convolution accelerator. It sits between the APB register block and the streaming datapath. It decodes the APB-programmed COMMAND on each conv_start, computes the expected AXIS beat count from InCh/OutCh/FLength, and gates the S/M stream handshakes. It also drives the compute start/done exchange and the level handshakes (F_writedone, B_writedone, rdy_to_transmit, transmit_done) back to the register block.

## Interface
- CNT_W, 22: width of the byte and beat counters.
- TIMEOUT_CYC, 4096: stall limit in cycles; used only with CONV_CTRL_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- conv_start  in  1  start level from APB; rising edge is sampled.
- COMMAND  in  3  0 idle, 1 load filter, 2 load bias, 3 load feature + compute, 4 transmit; 5–7 illegal.
- InCh, OutCh  in  9 each  channel counts.
- FLength  in  6  feature side length.
- rx_en  out  1  datapath ANDs into S_AXIS_TREADY.
- rx_fire  in  1  S_AXIS_TVALID & S_AXIS_TREADY.
- tx_en  out  1  datapath ANDs into M_AXIS_TVALID.
- tx_fire  in  1  M_AXIS_TVALID & M_AXIS_TREADY.
- tx_last  out  1  drives M_AXIS_TLAST.
- buf_sel  out  2  RX target buffer: 0 filter, 1 bias, 2 feature.
- compute_start  out  1  one-cycle pulse to the MAC array.
- compute_done  in  1  one-cycle pulse from the MAC array.
- F_writedone, B_writedone, rdy_to_transmit, transmit_done  out  1 each  completion levels.
- F_writedone_respond, B_writedone_respond, rdy_to_transmit_respond, transmit_done_respond  in  1 each  acknowledges.
- conv_done  out  1  one-cycle pulse.
- busy  out  1  high whenever state ≠ IDLE.
- err  out  1  sticky error flag.

## Operation
- States: IDLE, CALC, RX, COMP, TX, HS.
- IDLE:
  - On conv_start rising edge: latch COMMAND and channel params, clear err, go to CALC.
  - COMMAND 0: ignored.
  - COMMAND 5–7: set err, stay IDLE.
- CALC (1 cycle): compute bytes, then beats = (bytes+3)>>2, truncated to CNT_W.
  - cmd1: OutCh·InCh·9.
  - cmd2: OutCh.
  - cmd3: InCh·FLength².
  - cmd4: OutCh·FLength².
  - If beats = 0: set err, return to IDLE, no conv_done.
  - Otherwise: cmd1–3 go to RX with buf_sel = cmd−1; cmd4 goes to TX.
- RX:
  - rx_en = 1; count rx_fire.
  - On the final beat, cmd1/cmd2 go to HS raising F_writedone/B_writedone.
  - On the final beat, cmd3 goes to COMP and pulses compute_start in the first COMP cycle.
- COMP: wait for compute_done, then go to HS raising rdy_to_transmit.
- TX:
  - tx_en = 1; count tx_fire.
  - tx_last = tx_en & (count == beats−1).
  - On the final beat, go to HS raising transmit_done.
- HS:
  - Hold the selected level until its respond input is sampled high.
  - Then drop the level, pulse conv_done, return to IDLE.
  - Other respond inputs are ignored.
- conv_start edges outside IDLE are ignored, with no queuing.
- rx_fire while rx_en = 0, and tx_fire while tx_en = 0, are ignored.

## Timing
- All outputs are registered except tx_last, which is combinational from registered state and count.
- Reset values: every output 0; state IDLE; counters 0; err 0.
- rstn low mid-phase: next edge forces all of the above. The datapath must flush its own buffers.
- conv_start rising edge sampled at cycle N:
  - busy = 1 at N+1 (CALC).
  - rx_en or tx_en = 1 at N+2.
- Final rx_fire or tx_fire at cycle M:
  - rx_en/tx_en = 0 at M+1.
  - Completion level (or compute_start) = 1 at M+1.
- compute_done at cycle C: rdy_to_transmit = 1 at C+1.
- Respond high at cycle K:
  - Level = 0 and conv_done = 1 at K+1.
  - busy = 0 at K+1; a new conv_start edge is accepted from K+1.
- A respond already high on entry to HS completes the handshake in 1 cycle.
- Edge detector register conv_start_d resets to 0. conv_start held high through reset therefore registers an edge on the first cycle after reset.

## Configuration
- CONV_CTRL_TIMEOUT_EN defined:
  - A stall counter runs in RX, TX and COMP.
  - It is cleared on each rx_fire, tx_fire or compute_done.
  - When it reaches TIMEOUT_CYC: set err, drop rx_en/tx_en, go to IDLE without conv_done or a handshake level.
- Undefined: no counter; the block waits indefinitely.

## Test plan
- cmd1, InCh=3, OutCh=2: 54 bytes, 14 beats; rx_en low the cycle after the 14th rx_fire; F_writedone high until respond; conv_done pulse 1 cycle later.
- cmd2, OutCh=5: 2 beats with buf_sel=1; B_writedone handshake with respond held high → exits HS in 1 cycle.
- cmd3, InCh=1, FLength=4: 4 beats; compute_start pulse one cycle after the last beat; compute_done after 20 cycles → rdy_to_transmit next cycle.
- cmd4, OutCh=1, FLength=4, M_AXIS_TREADY toggling: exactly 4 tx_fire; tx_last only on the 4th; transmit_done follows.
- COMMAND=6 → err=1, busy never leaves IDLE past edge. OutCh=0 with cmd2 → err=1, no conv_done. Next legal start clears err.
- rstn low during RX beat 7 of 14 → all outputs 0 next cycle; new cmd1 restarts count from 0. With CONV_CTRL_TIMEOUT_EN and TIMEOUT_CYC=16, stalling rx_fire for 16 cycles → err=1, IDLE.
